// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - load/compute/flush/drain sequencer for a weight-stationary PE chain
// One job: shift N weights in, stream cfg_k activations, flush the skew, then drain N results.
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    cfg_k,
  output logic          busy,
  output logic          done,
  input  logic [DW-1:0] w_data,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] a_data,
  input  logic          a_valid,
  output logic          a_ready,
  output logic [DW-1:0] r_data,
  output logic          r_valid,
  input  logic          r_ready,
  output logic          arr_load_weight,
  output logic [DW-1:0] arr_weight_in,
  output logic [DW-1:0] arr_in_b,
  output logic          arr_chain_en,
  output logic [DW-1:0] arr_chain_in,
  input  logic [DW-1:0] arr_chain_out
);

  // One shared beat counter, wide enough for both N and a 255-beat activation run.
  localparam int CW = ($clog2(N + 1) > 8) ? $clog2(N + 1) : 8;
  localparam logic [CW-1:0] LAST_N = CW'(N - 1);
  localparam logic [CW-1:0] LAST_F = CW'((N > 1) ? N - 2 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FLUSH, DRAIN, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    k_q, k_d;
  logic [CW-1:0] last_a;

  assign last_a       = CW'(k_q) - CW'(1);
  assign arr_chain_in = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      k_q   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      k_q   <= k_d;
    end
  end

  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    k_d             = k_q;
    busy            = 1'b1;
    done            = 1'b0;
    w_ready         = 1'b0;
    a_ready         = 1'b0;
    r_valid         = 1'b0;
    r_data          = '0;
    arr_load_weight = 1'b0;
    arr_weight_in   = '0;
    arr_in_b        = '0;
    arr_chain_en    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = LOAD;
          k_d     = cfg_k;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        w_ready         = 1'b1;
        arr_weight_in   = w_data;
        arr_load_weight = w_valid;
        if (w_valid) begin
          if (cnt == LAST_N) begin
            cnt_d   = '0;
            state_d = (k_q == 8'd0) ? DRAIN : COMPUTE;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      COMPUTE: begin
        // A bubble must feed zero so it adds nothing to the accumulators.
        a_ready  = 1'b1;
        arr_in_b = a_valid ? a_data : '0;
        if (a_valid) begin
          if (cnt == last_a) begin
            cnt_d   = '0;
            state_d = (N == 1) ? DRAIN : FLUSH;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      FLUSH: begin
        if (cnt == LAST_F) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DRAIN: begin
        r_valid      = 1'b1;
        r_data       = arr_chain_out;
        arr_chain_en = r_ready;
        if (r_ready) begin
          if (cnt == LAST_N) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - randomized job-level check of systolic_ctrl against a phase-schedule model
// Each job is expanded into a per-cycle schedule of phases and inputs; outputs follow from the phase.
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int DW = 8;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_COMP  = 2;
  localparam int P_FLUSH = 3;
  localparam int P_DRAIN = 4;
  localparam int P_DONE  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cfg_k = '0;
  logic          busy, done;
  logic [DW-1:0] w_data = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [DW-1:0] a_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic          arr_load_weight;
  logic [DW-1:0] arr_weight_in;
  logic [DW-1:0] arr_in_b;
  logic          arr_chain_en;
  logic [DW-1:0] arr_chain_in;
  logic [DW-1:0] arr_chain_out = '0;

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k),
    .busy(busy), .done(done),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .arr_load_weight(arr_load_weight), .arr_weight_in(arr_weight_in),
    .arr_in_b(arr_in_b), .arr_chain_en(arr_chain_en),
    .arr_chain_in(arr_chain_in), .arr_chain_out(arr_chain_out)
  );

  typedef struct {
    int            phase;
    logic          start;
    logic [7:0]    k;
    logic          wv;
    logic [DW-1:0] wd;
    logic          av;
    logic [DW-1:0] ad;
    logic          rr;
    logic [DW-1:0] co;
  } cyc_t;

  cyc_t sched[$];
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t junk(input int ph, input bit hold, input logic [DW-1:0] chain);
    cyc_t c;
    c.phase = ph;
    c.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
    c.k     = 8'($urandom);
    c.wv    = 1'($urandom_range(0, 1));
    c.wd    = DW'($urandom);
    c.av    = 1'($urandom_range(0, 1));
    c.ad    = DW'($urandom);
    c.rr    = 1'($urandom_range(0, 1));
    c.co    = chain;
    return c;
  endfunction

  // mode 0: random stalls/data; 1: no stalls; 2: activation gaps; 3: five-cycle result stall
  function automatic int gap(input int mode, input int stream, input int i);
    case (mode)
      0:       return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      2:       return (stream == P_COMP && i > 0) ? 1 : 0;
      3:       return (stream == P_DRAIN && i == 2) ? 5 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic build(input int k, input int mode, input bit hold);
    cyc_t          c;
    logic [DW-1:0] chain = DW'($urandom);
    sched.delete();
    c = junk(P_IDLE, hold, chain);
    c.start = 1'b1;
    c.k = 8'(k);
    sched.push_back(c);
    for (int i = 0; i < N; i++) begin
      for (int g = gap(mode, P_LOAD, i); g > 0; g--) begin
        c = junk(P_LOAD, hold, chain); c.wv = 1'b0; sched.push_back(c);
      end
      c = junk(P_LOAD, hold, chain); c.wv = 1'b1;
      if (mode != 0) c.wd = DW'(i + 1);
      sched.push_back(c);
    end
    for (int i = 0; i < k; i++) begin
      for (int g = gap(mode, P_COMP, i); g > 0; g--) begin
        c = junk(P_COMP, hold, chain); c.av = 1'b0; sched.push_back(c);
      end
      c = junk(P_COMP, hold, chain); c.av = 1'b1;
      if (mode != 0) c.ad = DW'(5 + i);
      sched.push_back(c);
    end
    if (k > 0)
      for (int i = 0; i < N - 1; i++) sched.push_back(junk(P_FLUSH, hold, chain));
    // The chain output only moves after an accepted result, as a real PE chain would.
    for (int i = 0; i < N; i++) begin
      for (int g = gap(mode, P_DRAIN, i); g > 0; g--) begin
        c = junk(P_DRAIN, hold, chain); c.rr = 1'b0; sched.push_back(c);
      end
      c = junk(P_DRAIN, hold, chain); c.rr = 1'b1; sched.push_back(c);
      chain = DW'($urandom);
    end
    sched.push_back(junk(P_DONE, hold, chain));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_w_ready"}, w_ready, 0);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_r_valid"}, r_valid, 0);
    check({tag, "_load_w"}, arr_load_weight, 0);
    check({tag, "_chain_en"}, arr_chain_en, 0);
    check({tag, "_weight_in"}, arr_weight_in, 0);
    check({tag, "_in_b"}, arr_in_b, 0);
    check({tag, "_chain_in"}, arr_chain_in, 0);
    check({tag, "_r_data"}, r_data, 0);
  endtask

  task automatic run_job(input int k, input int mode, input bit hold, input int abort_at);
    build(k, mode, hold);
    foreach (sched[t]) begin
      cyc_t c = sched[t];
      @(negedge clk);
      start = c.start; cfg_k = c.k;
      w_valid = c.wv; w_data = c.wd;
      a_valid = c.av; a_data = c.ad;
      r_ready = c.rr; arr_chain_out = c.co;
      if (t == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_quiet("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        #1;
        check_quiet("postrst");
        return;
      end
      #1;
      check("busy", busy, c.phase != P_IDLE);
      check("done", done, c.phase == P_DONE);
      check("w_ready", w_ready, c.phase == P_LOAD);
      check("load_w", arr_load_weight, c.phase == P_LOAD && c.wv);
      check("weight_in", arr_weight_in, (c.phase == P_LOAD) ? c.wd : {DW{1'b0}});
      check("a_ready", a_ready, c.phase == P_COMP);
      check("in_b", arr_in_b, (c.phase == P_COMP && c.av) ? c.ad : {DW{1'b0}});
      check("r_valid", r_valid, c.phase == P_DRAIN);
      check("r_data", r_data, (c.phase == P_DRAIN) ? c.co : {DW{1'b0}});
      check("chain_en", arr_chain_en, c.phase == P_DRAIN && c.rr);
      check("chain_in", arr_chain_in, 0);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check_quiet("after_done");
  endtask

  initial begin
    start = 1'b1; w_valid = 1'b1; a_valid = 1'b1; r_ready = 1'b1;
    w_data = 8'hA5; a_data = 8'h5A; arr_chain_out = 8'h3C;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    #1;
    check_quiet("idle");

    run_job(3, 1, 1'b0, -1);
    run_job(3, 2, 1'b0, -1);
    run_job(3, 3, 1'b0, -1);
    run_job(0, 1, 1'b0, -1);
    run_job(3, 1, 1'b0, 1 + N + 1);
    run_job(3, 1, 1'b0, -1);
    run_job(2, 0, 1'b1, -1);
    run_job(255, 1, 1'b0, -1);
    for (int j = 0; j < 10; j++)
      run_job(int'($urandom_range(0, 12)), 0, (j % 3) == 0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
